// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared defaults and helpers for the processor datapath
package proc_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_NREGS    = 8;
    localparam int DEFAULT_IR_WIDTH = 10;
    localparam int PC_IDX           = DEFAULT_NREGS - 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - load-enable register with asynchronous active-low reset
module reg_cell #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q <= RESET_VAL;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - general registers, PC and IR loaded from the shared bus
module reg_bank
    import proc_pkg::*;
#(
    parameter int               WIDTH     = proc_pkg::DEFAULT_WIDTH,
    parameter int               NREGS     = proc_pkg::DEFAULT_NREGS,
    parameter int               IR_WIDTH  = proc_pkg::DEFAULT_IR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [WIDTH-1:0]          BusIn,
    input  logic [NREGS-1:0]          Rin,
    input  logic                      IRin,
    input  logic                      Prox,
    input  logic                      Clear,
    input  logic [clog2(NREGS)-1:0]   RaSel,
    input  logic [clog2(NREGS)-1:0]   RbSel,
    output logic [WIDTH-1:0]          Ra,
    output logic [WIDTH-1:0]          Rb,
    output logic [IR_WIDTH-1:0]       IR,
    output logic [WIDTH-1:0]          PC,
    output logic                      PcWrap,
    output logic                      RinErr
);

    localparam int PCI = NREGS - 1;

    logic [WIDTH-1:0] gpr [PCI];
    logic [WIDTH-1:0] pc_q;
    logic             multi_load;

    genvar g;
    generate
        for (g = 0; g < PCI; g++) begin : g_gpr
            reg_cell #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .Clock  (Clock),
                .Resetn (Resetn),
                .D      (BusIn),
                .En     (Rin[g]),
                .Q      (gpr[g])
            );
        end
    endgenerate

    reg_cell #(
        .WIDTH     (IR_WIDTH),
        .RESET_VAL ('0)
    ) u_ir (
        .Clock  (Clock),
        .Resetn (Resetn),
        .D      (BusIn[IR_WIDTH-1:0]),
        .En     (IRin),
        .Q      (IR)
    );

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_load = |(Rin & (Rin - NREGS'(1)));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q   <= '0;
            PcWrap <= 1'b0;
            RinErr <= 1'b0;
        end else begin
            PcWrap <= 1'b0;
            if (Rin[PCI]) begin
                pc_q <= BusIn;
            end else if (Prox) begin
                pc_q   <= pc_q + WIDTH'(1);
                PcWrap <= &pc_q;
            end else if (Clear) begin
                pc_q <= '0;
            end
            if (multi_load) begin
                RinErr <= 1'b1;
            end
        end
    end

    assign PC = pc_q;

    always_comb begin
        Ra = '0;
        Rb = '0;
        for (int i = 0; i < PCI; i++) begin
            if (int'(RaSel) == i) Ra = gpr[i];
            if (int'(RbSel) == i) Rb = gpr[i];
        end
        if (int'(RaSel) == PCI) Ra = pc_q;
        if (int'(RbSel) == PCI) Rb = pc_q;
    end

endmodule
